// File: rtl/cdc_handshake_pkg.sv
// cdc_handshake_pkg: shared handshake state encoding and default synchronizer depth
package cdc_handshake_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} hs_state_t;
  localparam int SYNC_DEPTH_DEF = 2;
endpackage

// File: rtl/cdc_handshake_tx_synchronizer.sv
// synchronizer: DEPTH-stage flop chain for an asynchronous bit, preloaded with the input on reset
module synchronizer #(
  parameter int DEPTH = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out
);
  logic [DEPTH-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[DEPTH-2:0], d_in};
  always_ff @(posedge clk_in) begin
    if (rst_in) sync_q <= {DEPTH{d_in}};
    else sync_q <= sync_d;
  end
  assign q_out = sync_q[DEPTH-1];
endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a four-phase req/ack crossing carrying a WIDTH-bit word
module cdc_handshake_tx
  import cdc_handshake_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SYNC_DEPTH = SYNC_DEPTH_DEF,
  parameter int COUNT_W    = 16
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic               req_out,
  output logic [WIDTH-1:0]   data_out,
  input  logic               ack_in,
  output logic               done_out,
  output logic [COUNT_W-1:0] xfer_count_out
);
  hs_state_t state_q, state_d;
  logic req_q, req_d, done_q, done_d, ack_s;
  logic [WIDTH-1:0] data_q, data_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  synchronizer #(.DEPTH(SYNC_DEPTH)) u_ack_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (ack_in),
    .q_out  (ack_s)
  );
  assign ready_out = (state_q == IDLE) && !ack_s;
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (valid_in && ready_out) begin
        data_d  = data_in;
        req_d   = 1'b1;
        state_d = REQ;
      end
      REQ: if (ack_s) begin
        req_d   = 1'b0;
        state_d = RELEASE;
      end
      RELEASE: if (!ack_s) begin
        state_d = IDLE;
        done_d  = 1'b1;
        cnt_d   = cnt_q + COUNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req_out        = req_q;
  assign data_out       = data_q;
  assign done_out       = done_q;
  assign xfer_count_out = cnt_q;
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed table and sequence checks for cdc_handshake_tx
module tb_cdc_handshake_tx;
  logic clk_in = 1'b0;
  logic rst_in, valid_in, ack_in, ready_out, req_out, done_out;
  logic [7:0] data_in, data_out;
  logic [3:0] xfer_count_out;
  int tests = 0, fails = 0, rises = 0;
  logic req_prev = 1'b0;
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       ack;
    logic       rdy;
    logic       req;
    logic [7:0] dout;
    logic       done;
    logic [3:0] cnt;
  } vec_t;
  vec_t tbl [16];
  cdc_handshake_tx #(.WIDTH(8), .SYNC_DEPTH(2), .COUNT_W(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .req_out        (req_out),
    .data_out       (data_out),
    .ack_in         (ack_in),
    .done_out       (done_out),
    .xfer_count_out (xfer_count_out)
  );
  always #5 clk_in = ~clk_in;
  always @(negedge clk_in) begin
    if (req_out && !req_prev) rises++;
    req_prev = req_out;
  end
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic [7:0] d, input int l1, input int l2, input logic [3:0] exp_cnt);
    int n;
    logic stable;
    n = 0;
    while (!ready_out && n < 50) begin step(); n++; end
    chk("xfer_ready", ready_out, 1);
    valid_in = 1'b1;
    data_in  = d;
    step();
    valid_in = 1'b0;
    data_in  = 8'($urandom);
    chk("xfer_req_on", req_out, 1);
    chk("xfer_data", data_out, d);
    stable = 1'b1;
    repeat (l1) begin step(); stable &= (data_out === d) && req_out; end
    ack_in = 1'b1;
    n = 0;
    while (req_out && n < 50) begin step(); n++; stable &= (data_out === d); end
    chk("xfer_req_off", req_out, 0);
    repeat (l2) begin step(); stable &= (data_out === d) && !req_out; end
    ack_in = 1'b0;
    n = 0;
    while (!done_out && n < 50) begin step(); n++; stable &= (data_out === d) && !req_out; end
    chk("xfer_done", done_out, 1);
    chk("xfer_cnt", xfer_count_out, exp_cnt);
    chk("xfer_done_ready", ready_out, 1);
    chk("xfer_stable", stable, 1);
  endtask
  task automatic set_row(input int i, input logic v, input logic [7:0] d, input logic a,
                         input logic r, input logic q, input logic [7:0] o, input logic dn, input logic [3:0] c);
    tbl[i] = '{valid: v, data: d, ack: a, rdy: r, req: q, dout: o, done: dn, cnt: c};
  endtask
  initial begin
    int base, n;
    logic saw_done;
    set_row(0, 1, 8'hA5, 0, 1, 0, 8'h00, 0, 0);
    for (int i = 1; i <= 4; i++) set_row(i, 1, 8'h3C, 0, 0, 1, 8'hA5, 0, 0);
    for (int i = 5; i <= 7; i++) set_row(i, 1, 8'h3C, 1, 0, 1, 8'hA5, 0, 0);
    for (int i = 8; i <= 10; i++) set_row(i, 1, 8'h3C, 1, 0, 0, 8'hA5, 0, 0);
    for (int i = 11; i <= 13; i++) set_row(i, 1, 8'h3C, 0, 0, 0, 8'hA5, 0, 0);
    set_row(14, 1, 8'h3C, 0, 1, 0, 8'hA5, 1, 1);
    set_row(15, 0, 8'h3C, 0, 0, 1, 8'h3C, 0, 1);
    rst_in = 1'b1; valid_in = 1'b0; ack_in = 1'b0; data_in = 8'h00;
    step(); step();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_ready", ready_out, 1);
    chk("rst_req", req_out, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_cnt", xfer_count_out, 0);
    chk("rst_done", done_out, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      valid_in = tbl[i].valid;
      data_in  = tbl[i].data;
      ack_in   = tbl[i].ack;
      @(negedge clk_in);
      chk($sformatf("c%0d_ready", i), ready_out, tbl[i].rdy);
      chk($sformatf("c%0d_req", i), req_out, tbl[i].req);
      chk($sformatf("c%0d_data", i), data_out, tbl[i].dout);
      chk($sformatf("c%0d_done", i), done_out, tbl[i].done);
      chk($sformatf("c%0d_cnt", i), xfer_count_out, tbl[i].cnt);
      step();
    end
    ack_in = 1'b1;
    n = 0;
    while (req_out && n < 50) begin step(); n++; end
    chk("second_req_off", req_out, 0);
    ack_in = 1'b0;
    n = 0;
    while (!done_out && n < 50) begin step(); n++; end
    chk("second_done", done_out, 1);
    chk("second_cnt", xfer_count_out, 2);
    chk("second_data", data_out, 8'h3C);
    rst_in = 1'b1; ack_in = 1'b1;
    step(); step();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("ackrst_ready", ready_out, 0);
    chk("ackrst_req", req_out, 0);
    chk("ackrst_cnt", xfer_count_out, 0);
    saw_done = 1'b0;
    repeat (3) begin step(); saw_done |= done_out; end
    chk("ackrst_ready_held", ready_out, 0);
    ack_in = 1'b0;
    @(negedge clk_in);
    saw_done |= done_out;
    chk("ackrst_ready_c0", ready_out, 0);
    step();
    @(negedge clk_in);
    saw_done |= done_out;
    chk("ackrst_ready_c1", ready_out, 0);
    step();
    @(negedge clk_in);
    saw_done |= done_out;
    chk("ackrst_ready_c2", ready_out, 1);
    chk("ackrst_no_done", saw_done, 0);
    step();
    valid_in = 1'b1; data_in = 8'h5A;
    step();
    valid_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_req_on", req_out, 1);
    chk("midrst_data", data_out, 8'h5A);
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_req_off", req_out, 0);
    chk("midrst_ready", ready_out, 1);
    chk("midrst_cnt", xfer_count_out, 0);
    chk("midrst_done", done_out, 0);
    step();
    base = rises;
    for (int i = 0; i < 17; i++)
      xfer(8'($urandom), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 4'(i + 1));
    step();
    chk("wrap_cnt", xfer_count_out, 1);
    chk("wrap_req_rises", rises - base, 17);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-domain half of a four-phase req/ack crossing that moves a WIDTH-bit word into another clock domain. It accepts a word on a valid/ready port and drives `req_out` with the word held stable on `data_out`. It synchronizes the asynchronous `ack_in` from the destination domain and completes the handshake. It sits at the boundary of any clk_in-domain block that must post control words or status to a foreign-clock consumer; the destination-side responder is a separate block.

## Interface
- WIDTH, 8: data word width in bits.
- SYNC_DEPTH, 2: flip-flop stages on the `ack_in` synchronizer; legal values are ≥2.
- COUNT_W, 16: width of the completed-transfer counter.

- clk_in  input  1  sole clock. One clock; reset is synchronous and active-high.
- rst_in  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  word to send.
- valid_in  input  1  upstream asserts that `data_in` is valid.
- ready_out  output  1  block can accept a word this cycle.
- req_out  output  1  four-phase request to the destination domain. Registered and glitch-free.
- data_out  output  WIDTH  registered word. Stable while `req_out` is high and through the release phase.
- ack_in  input  1  asynchronous acknowledge from the destination domain.
- done_out  output  1  one-cycle pulse when a handshake fully completes.
- xfer_count_out  output  COUNT_W  number of completed handshakes. Wraps modulo 2^COUNT_W.

## Operation
- `ack_s` is `ack_in` after SYNC_DEPTH flops. Only `ack_s` is used internally; raw `ack_in` never reaches logic.
- The FSM has three states: IDLE, REQ, RELEASE.
- IDLE:
  - `ready_out = (state==IDLE) && !ack_s`.
  - If `valid_in && ready_out`: capture `data_in` into `data_out`, set `req_out` to 1, go to REQ.
- REQ: hold. When `ack_s==1`: set `req_out` to 0, go to RELEASE.
- RELEASE: when `ack_s==0`: go to IDLE, pulse `done_out`, increment `xfer_count_out`.
- `data_out` changes only on an accepted capture in IDLE. Otherwise it holds.
- If `ack_s` is high in IDLE (stale ack, or ack high at reset), the block stays in IDLE with `ready_out` low until `ack_s` falls.
- `valid_in` is ignored outside IDLE. Upstream holds the word until `ready_out`; dropped words are upstream's fault.
- Reset values:
  - state = IDLE, `req_out` = 0, `data_out` = 0, `done_out` = 0, `xfer_count_out` = 0.
  - The synchronizer chain is filled with the current `ack_in` value, so there is no spurious edge after reset.
- Reset mid-handshake drops `req_out` to 0 on the reset edge and abandons the word. The responder must tolerate the early request release.

## Timing
- Accept at edge t0 (cycle 0, `valid_in && ready_out`). In cycle 1, `req_out`=1 and `data_out`=word.
- `ack_in` rising, first sampled at edge k, gives `ack_s`=1 in cycle k+SYNC_DEPTH. `req_out` is 0 from cycle k+SYNC_DEPTH+1.
- `ack_in` falling, sampled at edge m, gives `ack_s`=0 in cycle m+SYNC_DEPTH. The FSM enters IDLE in cycle m+SYNC_DEPTH+1. `done_out`=1 and the counter increments in that same cycle.
- Minimum back-to-back spacing is 1 cycle in IDLE plus both synchronizer latencies plus responder latency. There is no pipelining; exactly one word is in flight.
- `done_out` and `ready_out` may be high in the same cycle. A new accept in that cycle is legal.
- Counter wrap: from 2^COUNT_W−1, the next completion yields 0.

## Structure
- Shared package holds:
  - the `hs_state_t` enum {IDLE, REQ, RELEASE}, so the future responder and the debug taps share encoding;
  - the default SYNC_DEPTH constant.
- One sub-module: the existing `synchronizer`, instantiated with SYNC_DEPTH on `ack_in`, sharing `clk_in`/`rst_in`.
- The FSM, data register and counter live in the top module.

## Test plan
- Reset with `ack_in`=0 → `ready_out`=1, `req_out`=0, `data_out`=0, `xfer_count_out`=0 after one edge.
- Single transfer (SYNC_DEPTH=2), data_in=0xA5 accepted at t0, bench responder raises `ack_in` at cycle 5 and drops it 3 cycles after seeing `req_out` low:
  - `req_out`=1 over cycles 1–7 with `data_out`=0xA5;
  - `req_out`=0 from cycle 8;
  - one `done_out` pulse; count=1.
- `valid_in` held high with new data while in REQ/RELEASE → `data_out` stays 0xA5. The next word is accepted only once the block is back in IDLE.
- Reset with `ack_in`=1 held → `ready_out`=0. `ready_out` goes to 1 two cycles after `ack_in` drops, with no `done_out` pulse.
- `rst_in` pulsed while in REQ → `req_out`=0 and state IDLE the next cycle; count unchanged.
- COUNT_W=4, 17 random-latency transfers → count reads 1. Every `data_out` matches its accepted word; no `req_out` glitches.
